// File: rtl/des_feistel_iter.sv
// Iterative DES Feistel round engine: one round per clock between IP and IP^-1.
// E(R) xor subkey leaves through sbox_in; sbox_out returns through P, the L xor and the half swap.
module des_feistel_iter #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ready,
  input  logic [63:0] din,
  output logic [3:0]  round_idx,
  input  logic [47:0] subkey,
  output logic [47:0] sbox_in,
  input  logic [31:0] sbox_out,
  output logic [63:0] dout,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [31:0] l_q, l_d;
  logic [31:0] r_q, r_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] dout_q, dout_d;

  logic [47:0] e_r;
  logic [31:0] p_out;
  logic [31:0] f_xor;

  // Tables number bits 1..N from the MSB, so table entry k maps to vector index N-k.
  always_comb begin
    e_r   = '0;
    p_out = '0;
    for (int n = 0; n < 48; n++) begin
      e_r[6'(47 - n)] = r_q[5'(32 - E_TBL[n])];
    end
    for (int n = 0; n < 32; n++) begin
      p_out[5'(31 - n)] = sbox_out[5'(32 - P_TBL[n])];
    end
  end

  assign sbox_in   = e_r ^ subkey;
  assign f_xor     = l_q ^ p_out;
  assign ready     = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign round_idx = (state_q == RUN) ? cnt_q : 4'd0;
  assign dout      = dout_q;

  // NOTE: every variable gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          l_d     = din[63:32];
          r_d     = din[31:0];
          cnt_d   = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_CNT) begin
          // Last round skips the swap: R16 goes high, L16 low; cnt stops here so it never wraps.
          dout_d  = {f_xor, r_q};
          state_d = DONE;
        end else begin
          l_d   = r_q;
          r_d   = f_xor;
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments make every register sample the pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      l_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_des_feistel_iter.sv
// Directed bench for des_feistel_iter: bench-side S-boxes and key schedule (key 133457799BBCDFF1),
// one 16-round and one 1-round instance, FIPS worked-example vectors.
module tb_des_feistel_iter;

  localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
  localparam logic [63:0] DIN_T1  = 64'hCC00CCFF_F0AAF0AA;
  localparam logic [63:0] DOUT_T1 = 64'h0A4CD995_43423234;

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int SBOX [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, start1;
  logic        zero_sbox;
  logic [63:0] din;
  logic [47:0] ks [16];

  logic        ready16, done16, ready1, done1;
  logic [3:0]  round_idx16, round_idx1;
  logic [47:0] subkey16, subkey1, sbox_in16, sbox_in1;
  logic [31:0] sbox_out16, sbox_out1;
  logic [63:0] dout16, dout1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [47:0] e_f(logic [31:0] r);
    logic [47:0] o;
    for (int n = 0; n < 48; n++) o[47 - n] = r[32 - E_TBL[n]];
    return o;
  endfunction

  function automatic logic [31:0] p_f(logic [31:0] s);
    logic [31:0] o;
    for (int n = 0; n < 32; n++) o[31 - n] = s[32 - P_TBL[n]];
    return o;
  endfunction

  function automatic logic [31:0] sbox_f(logic [47:0] x);
    logic [31:0] o;
    logic [5:0]  six;
    int          row, col;
    for (int i = 0; i < 8; i++) begin
      six = x[47 - 6 * i -: 6];
      row = {six[5], six[0]};
      col = six[4:1];
      o[31 - 4 * i -: 4] = 4'(SBOX[i][row * 16 + col]);
    end
    return o;
  endfunction

  // Textbook preoutput R16||L16 after n rounds.
  function automatic logic [63:0] des_ref(logic [63:0] x, int n);
    logic [31:0] l, r, t;
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < n; i++) begin
      t = r;
      r = l ^ p_f(sbox_f(e_f(r) ^ ks[i]));
      l = t;
    end
    return {r, l};
  endfunction

  task automatic build_ks(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    for (int n = 0; n < 56; n++) cd[55 - n] = key[64 - PC1[n]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int n = 0; n < 48; n++) ks[r][47 - n] = cd[56 - PC2[n]];
    end
  endtask

  assign subkey16   = ks[round_idx16];
  assign subkey1    = ks[round_idx1];
  assign sbox_out16 = zero_sbox ? 32'h0 : sbox_f(sbox_in16);
  assign sbox_out1  = sbox_f(sbox_in1);

  des_feistel_iter #(.ROUNDS(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .start     (start16),
    .ready     (ready16),
    .din       (din),
    .round_idx (round_idx16),
    .subkey    (subkey16),
    .sbox_in   (sbox_in16),
    .sbox_out  (sbox_out16),
    .dout      (dout16),
    .done      (done16)
  );

  des_feistel_iter #(.ROUNDS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .ready     (ready1),
    .din       (din),
    .round_idx (round_idx1),
    .subkey    (subkey1),
    .sbox_in   (sbox_in1),
    .sbox_out  (sbox_out1),
    .dout      (dout1),
    .done      (done1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Launch one 16-round block from IDLE and follow it to completion.
  task automatic run16(input string tag, input logic [63:0] d, input logic [63:0] exp,
                       input bit detail, input bit hold, input logic [63:0] hold_val);
    int n;
    bit seen;
    din     = d;
    start16 = 1'b1;
    check({tag, " ready_before"}, ready16, 1);
    step();
    start16 = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (detail && n == 0) check({tag, " sbox_in_r0"}, sbox_in16, 48'h6117BA866527);
      if (detail && n == 1) begin
        check({tag, " L_after_r1"}, dut16.l_q, 32'hF0AAF0AA);
        check({tag, " R_after_r1"}, dut16.r_q, 32'hEF4A6544);
      end
      if (detail && !done16) check({tag, " round_idx"}, round_idx16, 64'(n));
      if (!done16) check({tag, " ready_busy"}, ready16, 0);
      if (hold && !done16) check({tag, " dout_hold"}, dout16, hold_val);
      if (done16) seen = 1'b1;
      else begin
        step();
        n++;
      end
    end
    check({tag, " latency"}, 64'(n), 16);
    check({tag, " dout"}, dout16, exp);
    step();
    check({tag, " done_width"}, done16, 0);
    check({tag, " ready_after"}, ready16, 1);
    check({tag, " dout_kept"}, dout16, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int pulses;
    rst       = 1'b1;
    start16   = 1'b0;
    start1    = 1'b0;
    zero_sbox = 1'b0;
    din       = '0;
    build_ks(KEY);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst ready16", ready16, 1);
    check("rst done16", done16, 0);
    check("rst dout16", dout16, 0);
    check("rst round_idx16", round_idx16, 0);
    check("rst ready1", ready1, 1);
    check("rst dout1", dout1, 0);

    // FIPS worked example.
    run16("t1", DIN_T1, DOUT_T1, 1'b1, 1'b0, '0);

    // Zero S-box response leaves only the half swaps.
    zero_sbox = 1'b1;
    run16("t2", 64'h0123456789ABCDEF, 64'h89ABCDEF_01234567, 1'b0, 1'b1, DOUT_T1);
    zero_sbox = 1'b0;

    // start held high: one acceptance every 18 cycles.
    din     = DIN_T1;
    start16 = 1'b1;
    for (int k = 0; k < 36; k++) begin
      step();
      check("t3 ready", ready16, ((k % 18) == 17) ? 1 : 0);
      check("t3 done", done16, ((k % 18) == 16) ? 1 : 0);
      if ((k % 18) == 16) check("t3 dout", dout16, DOUT_T1);
    end
    start16 = 1'b0;

    // Reset in the middle of round 7 aborts the block.
    din     = 64'h0123456789ABCDEF;
    start16 = 1'b1;
    step();
    start16 = 1'b0;
    n = 0;
    while (round_idx16 != 4'd7 && n < 20) begin
      step();
      n++;
    end
    check("t4 reach_round7", round_idx16, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t4 ready", ready16, 1);
    check("t4 done", done16, 0);
    check("t4 dout", dout16, 0);
    check("t4 round_idx", round_idx16, 0);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done16) pulses++;
    end
    check("t4 no_done", 64'(pulses), 0);
    run16("t4 rerun", DIN_T1, DOUT_T1, 1'b0, 1'b1, 64'h0);

    // Back-to-back: next start issued on the first IDLE cycle after done.
    run16("t6", 64'h0, des_ref(64'h0, 16), 1'b0, 1'b1, DOUT_T1);

    // Single-round instance.
    din    = DIN_T1;
    start1 = 1'b1;
    check("t5 ready_before", ready1, 1);
    step();
    start1 = 1'b0;
    check("t5 sbox_in", sbox_in1, 48'h6117BA866527);
    check("t5 done_early", done1, 0);
    check("t5 ready_busy", ready1, 0);
    step();
    check("t5 done", done1, 1);
    check("t5 dout", dout1, 64'hEF4A6544_F0AAF0AA);
    step();
    check("t5 done_width", done1, 0);
    check("t5 ready_after", ready1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
